// File: rtl/compc_seq.sv
// Sequential magnitude comparator: CHUNK bits per cycle, MSB chunk first, early exit.
// Define COMPC_SIGNED_EN to compare two's-complement operands instead of unsigned.
module compc_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             x,
  output logic             y,
  output logic             z
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

`ifdef COMPC_SIGNED_EN
  // Flipping both sign bits maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
`else
  localparam logic [WIDTH-1:0] MSB_MASK = '0;
`endif

  typedef enum logic {IDLE, CMP} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;

  assign busy    = (state == CMP);
  assign chunk_a = op_a[idx*CHUNK +: CHUNK];
  assign chunk_b = op_b[idx*CHUNK +: CHUNK];

  // NOTE: all state in this block uses non-blocking assignments so every
  // register samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      // NOTE: operand registers are cleared too, so a reset leaves no stale
      // operand data visible in the datapath.
      op_a  <= '0;
      op_b  <= '0;
      done  <= 1'b0;
      x     <= 1'b0;
      y     <= 1'b0;
      z     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a ^ MSB_MASK;
            op_b  <= b ^ MSB_MASK;
            idx   <= IDX_W'(NCHUNK - 1);
            state <= CMP;
          end
        end
        CMP: begin
          if (chunk_a > chunk_b) begin
            x     <= 1'b0;
            y     <= 1'b1;
            z     <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (chunk_a < chunk_b) begin
            x     <= 1'b1;
            y     <= 1'b0;
            z     <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (idx == '0) begin
            x     <= 1'b0;
            y     <= 1'b0;
            z     <= 1'b1;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compc_seq.sv
// Directed bench for compc_seq: an 8-bit/2-bit-chunk instance and a single-chunk 4-bit instance.
module tb_compc_seq;

  logic       clk = 1'b0;
  logic       rst, start, start1;
  logic [7:0] a, b;
  logic [3:0] a1, b1;
  logic       busy, done, x, y, z;
  logic       busy1, done1, x1, y1, z1;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  compc_seq #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .x(x), .y(y), .z(z)
  );

  compc_seq #(.WIDTH(4), .CHUNK(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .x(x1), .y(y1), .z(z1)
  );

  // One full compare on the 8-bit instance; operands are scrambled after acceptance.
  task automatic run_compare(input string name, input logic [7:0] va, input logic [7:0] vb,
                             input int k_exp, input logic [2:0] xyz_exp);
    logic [2:0] prev;
    int         cyc;
    bit         seen;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    prev = {x, y, z};
    @(negedge clk);
    start = 1'b0; a = ~va; b = ~vb;
    n_vec++;
    if ({busy, done, x, y, z} !== {1'b1, 1'b0, prev}) begin
      n_err++;
      $display("FAIL %s accept: busy,done,xyz=%b expected %b", name,
               {busy, done, x, y, z}, {1'b1, 1'b0, prev});
    end
    cyc = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (busy) cyc++;
        @(negedge clk);
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s timeout: no done within 10 cycles, expected after %0d", name, k_exp);
    end
    n_vec++;
    if (cyc != k_exp) begin
      n_err++;
      $display("FAIL %s latency: busy cycles=%0d expected %0d", name, cyc, k_exp);
    end
    n_vec++;
    if ({busy, done, x, y, z} !== {1'b0, 1'b1, xyz_exp}) begin
      n_err++;
      $display("FAIL %s result: busy,done,xyz=%b expected %b", name,
               {busy, done, x, y, z}, {1'b0, 1'b1, xyz_exp});
    end
    @(negedge clk);
    n_vec++;
    if ({busy, done, x, y, z} !== {1'b0, 1'b0, xyz_exp}) begin
      n_err++;
      $display("FAIL %s hold: busy,done,xyz=%b expected %b", name,
               {busy, done, x, y, z}, {1'b0, 1'b0, xyz_exp});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; start1 = 1'b1;
    a = 8'h12; b = 8'h34; a1 = 4'h1; b1 = 4'h2;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done, x, y, z, busy1, done1, x1, y1, z1} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_state: got %b expected %b",
               {busy, done, x, y, z, busy1, done1, x1, y1, z1}, 10'b0);
    end
    rst = 1'b0; start = 1'b0; start1 = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, done, busy1, done1} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy,done,busy1,done1=%b expected 0000", {busy, done, busy1, done1});
    end
  endtask

  task automatic test_unsigned();
    run_compare("eq_a5",   8'hA5, 8'hA5, 4, 3'b001);
    run_compare("lsb_lt",  8'h34, 8'h35, 4, 3'b100);
    run_compare("chunk1",  8'h12, 8'h1F, 3, 3'b100);
    run_compare("lsb_gt",  8'hC3, 8'hC1, 4, 3'b010);
  endtask

  task automatic test_sign();
`ifdef COMPC_SIGNED_EN
    run_compare("s_80_7f", 8'h80, 8'h7F, 1, 3'b100);
    run_compare("s_ff_00", 8'hFF, 8'h00, 1, 3'b100);
`else
    run_compare("u_80_7f", 8'h80, 8'h7F, 1, 3'b010);
    run_compare("u_ff_00", 8'hFF, 8'h00, 1, 3'b010);
`endif
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit seen;
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    n_vec++;
    if ({busy, done} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_busy2: busy,done=%b expected 10", {busy, done});
    end
    a = 8'h00; b = 8'h00; start = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy, done, x, y, z} !== 5'b01010) begin
      n_err++;
      $display("FAIL b2b_first: busy,done,xyz=%b expected 01010", {busy, done, x, y, z});
    end
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if ({busy, done, x, y, z} !== 5'b10010) begin
      n_err++;
      $display("FAIL b2b_accept: busy,done,xyz=%b expected 10010", {busy, done, x, y, z});
    end
    cyc = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (busy) cyc++;
        @(negedge clk);
      end
    end
    n_vec++;
    if (!seen || cyc != 4 || {x, y, z} !== 3'b001) begin
      n_err++;
      $display("FAIL b2b_second: seen=%0d cycles=%0d xyz=%b expected seen=1 cycles=4 xyz=001",
               seen, cyc, {x, y, z});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    a = 8'h0F; b = 8'h0E; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, done} !== 2'b10) begin
      n_err++;
      $display("FAIL abort_busy: busy,done=%b expected 10", {busy, done});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({busy, done, x, y, z} !== 5'b0) begin
      n_err++;
      $display("FAIL abort_reset: busy,done,xyz=%b expected 00000", {busy, done, x, y, z});
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, done, x, y, z} !== 5'b0) begin
        n_err++;
        $display("FAIL abort_idle%0d: busy,done,xyz=%b expected 00000", i, {busy, done, x, y, z});
      end
    end
    run_compare("after_abort", 8'h0F, 8'h0E, 4, 3'b010);
  endtask

  task automatic test_single_chunk();
    logic [2:0] exp_xyz;
`ifdef COMPC_SIGNED_EN
    exp_xyz = 3'b010;
`else
    exp_xyz = 3'b100;
`endif
    @(negedge clk);
    a1 = 4'h3; b1 = 4'h9; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
    n_vec++;
    if ({busy1, done1} !== 2'b10) begin
      n_err++;
      $display("FAIL single_busy: busy,done=%b expected 10", {busy1, done1});
    end
    @(negedge clk);
    n_vec++;
    if ({busy1, done1, x1, y1, z1} !== {2'b01, exp_xyz}) begin
      n_err++;
      $display("FAIL single_result: busy,done,xyz=%b expected %b",
               {busy1, done1, x1, y1, z1}, {2'b01, exp_xyz});
    end
    a1 = 4'h6; b1 = 4'h6; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy1, done1, x1, y1, z1} !== 5'b01001) begin
      n_err++;
      $display("FAIL single_eq: busy,done,xyz=%b expected 01001", {busy1, done1, x1, y1, z1});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    a = '0; b = '0; a1 = '0; b1 = '0;
    test_reset();
    test_unsigned();
    test_sign();
    test_back_to_back();
    test_reset_abort();
    test_single_chunk();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
